// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults and colour type shared by the VGA timing generator
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int COLOR_W_DEF  = 4;
  localparam int CNT_W_DEF    = 11;
  typedef struct packed {
    logic [COLOR_W_DEF-1:0] b, g, r;
  } rgb_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-fetch bus between the timing generator (master) and the pixel source (slave)
interface vga_timing_gen_if #(
  parameter int CNT_W   = vga_pkg::CNT_W_DEF,
  parameter int COLOR_W = vga_pkg::COLOR_W_DEF
);
  logic                 pixel_req, line_start, frame_start;
  logic [CNT_W-1:0]     X_pix, Y_pix;
  logic [3*COLOR_W-1:0] pixel_color;
  modport master (output pixel_req, X_pix, Y_pix, line_start, frame_start, input pixel_color);
  modport slave (input pixel_req, X_pix, Y_pix, line_start, frame_start, output pixel_color);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-stage, W-bit shift register that clears to zero on reset
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         pixel_clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge pixel_clk)
    if (reset) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with PIX_LAT-aligned registered RGB output.
// Defining VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern selected by pattern_sel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int PIX_LAT  = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               pixel_clk,
  input  logic               reset,
  vga_timing_gen_if.master   pix,
  input  logic               pattern_sel,
  output logic [15:0]        frame_cnt,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic [COLOR_W-1:0] VGA_BUS_R,
  output logic [COLOR_W-1:0] VGA_BUS_G,
  output logic [COLOR_W-1:0] VGA_BUS_B
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  typedef struct packed {
    logic [COLOR_W-1:0] b, g, r;
  } color_t;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_raw, vs_raw, req_raw, hs_d, vs_d, req_d, frame_seen;
  color_t           color;
  always_ff @(posedge pixel_clk)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
    end
  assign req_raw         = h_cnt < H_ACT && v_cnt < V_ACT;
  assign hs_raw          = h_cnt >= HS_BEG && h_cnt < HS_END;
  assign vs_raw          = v_cnt >= VS_BEG && v_cnt < VS_END;
  assign pix.pixel_req   = req_raw;
  assign pix.X_pix       = req_raw ? h_cnt : '0;
  assign pix.Y_pix       = req_raw ? v_cnt : '0;
  assign pix.line_start  = !reset && h_cnt == '0 && v_cnt < V_ACT;
  assign pix.frame_start = !reset && h_cnt == '0 && v_cnt == '0;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]           bar;
  logic [3*COLOR_W-1:0] pat_raw, pat_d;
  logic                 pat_sel_d;
  assign bar     = 3'((32'(h_cnt) * 8) / H_ACTIVE);
  assign pat_raw = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
  // Pattern colour and its select travel with the syncs so a switch lands on a pixel boundary
  vga_delay_line #(.W(3*COLOR_W + 4), .D(PIX_LAT)) u_dly (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .d({pattern_sel, pat_raw, hs_raw, vs_raw, req_raw}),
    .q({pat_sel_d, pat_d, hs_d, vs_d, req_d})
  );
  assign color = pat_sel_d ? pat_d : pix.pixel_color;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  vga_delay_line #(.W(3), .D(PIX_LAT)) u_dly (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .d({hs_raw, vs_raw, req_raw}),
    .q({hs_d, vs_d, req_d})
  );
  assign color = pix.pixel_color;
`endif
  always_ff @(posedge pixel_clk)
    if (reset) begin
      VGA_HS     <= ~HS_POL;
      VGA_VS     <= ~VS_POL;
      VGA_DE     <= 1'b0;
      VGA_BUS_R  <= '0;
      VGA_BUS_G  <= '0;
      VGA_BUS_B  <= '0;
      frame_cnt  <= '0;
      frame_seen <= 1'b0;
    end else begin
      VGA_HS    <= hs_d ? HS_POL : ~HS_POL;
      VGA_VS    <= vs_d ? VS_POL : ~VS_POL;
      VGA_DE    <= req_d;
      VGA_BUS_R <= req_d ? color.r : '0;
      VGA_BUS_G <= req_d ? color.g : '0;
      VGA_BUS_B <= req_d ? color.b : '0;
      // The frame that starts out of reset is not counted as completed
      if (pix.frame_start) begin
        frame_seen <= 1'b1;
        frame_cnt  <= frame_cnt + {15'd0, frame_seen};
      end
    end
endmodule
